imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Sequential immediate encoder, the inverse of datapath immediate extension. Takes a 32-bit value and an ImmSrc request, checks whether the value fits the requested instruction immediate field, and returns the 24-bit field plus the ImmSrc that decodes it. Auto mode (ImmSrc=11) searches the encodings one per cycle and returns the narrowest that fits. Used by the program loader/assembler path and as a self-check partner for the extension logic.

Parameters:
ALLOW_AUTO, 1, when 0, ImmSrc=11 is rejected: one EVAL cycle, then DONE with Fits=0 and SrcOut=11.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
InValid  in  1  request valid
InReady  out  1  encoder can accept a request
Value  in  32  value to encode
ImmSrc  in  2  00=8-bit unsigned, 01=12-bit unsigned, 10=24-bit signed word-shifted branch, 11=auto
OutValid  out  1  result valid
OutReady  in  1  consumer accepts result
Field  out  24  encoded immediate field, zero-padded in the high bits for 00/01
SrcOut  out  2  encoding chosen, or last encoding tried on failure
Fits  out  1  1 = Value is exactly representable

Behaviour:
- Reset, synchronous on the clk edge with reset=1, overriding every other input:
  - state=IDLE, InReady=1, OutValid=0, Field=0, SrcOut=00, Fits=0.
  - Reset during EVAL or DONE abandons the request; OutValid=0 from the next cycle.
- IDLE:
  - InReady=1.
  - Accept edge = InValid&InReady: latch Value and ImmSrc; candidate = (ImmSrc==11) ? 00 : ImmSrc; go to EVAL.
- EVAL:
  - InReady=0; one cycle per candidate.
  - Fit rules:
    - 00: Value[31:8]==0; field={16'b0,Value[7:0]}.
    - 01: Value[31:12]==0; field={12'b0,Value[11:0]}.
    - 10: Value[1:0]==0 and Value[31:25] all equal; field=Value[25:2].
    - 11 (only reachable with ALLOW_AUTO=0): never fits.
  - Fit: register Field=field, SrcOut=candidate, Fits=1; go to DONE.
  - No fit, auto request, candidate<10: candidate+1; stay in EVAL.
  - Otherwise: Field=0, SrcOut=candidate, Fits=0; go to DONE.
- DONE:
  - OutValid=1; Field, SrcOut and Fits held stable until the OutReady edge.
  - On OutReady: OutValid=0 next cycle; go to IDLE.
  - InReady=0, so there is no overlap. A new request is accepted no earlier than the cycle after the OutReady edge.
- Latency, counted from the accept edge to the first cycle with OutValid=1:
  - Fixed request: 2 edges.
  - Auto: 2 / 3 / 4 edges when the value fits 00 / 01 / 10, and 4 edges on a total miss.
- Changes on Value or ImmSrc after the accept edge are ignored.
- Round-trip invariant: when Fits=1, extending Field per SrcOut reproduces Value exactly:
  - 00/01: zero-extend the low 8/12 bits.
  - 10: {{6{Field[23]}},Field,2'b00}.
- Value 0 in auto mode returns SrcOut=00, Field=0.

Decomposition:
- Shared package imm_pkg:
  - ImmSrc constants IMM_8U=2'b00, IMM_12U=2'b01, IMM_BR24=2'b10, IMM_AUTO=2'b11.
  - State enum {IDLE, EVAL, DONE}.
  - Widths: 32 for the value, 24 for the field.
- Sub-module imm_fit_check: combinational; inputs candidate and Value; outputs fits and field.
- imm_encoder holds the FSM, the candidate register and the output registers.

Test Plan:
- Reset with InValid=0 -> InReady=1, OutValid=0, Field=0, SrcOut=00, Fits=0. Assert reset while in EVAL -> IDLE next cycle, no OutValid.
- Fixed requests:
  - 00, Value=0x000000A5 -> Fits=1, Field=0x0000A5, OutValid 2 edges after accept.
  - 00, Value=0x00000100 -> Fits=0, SrcOut=00, Field=0.
- Auto requests:
  - Value=0x00000ABC -> Fits=1, SrcOut=01, Field=0x000ABC, latency 3.
  - Value=0xFFFFFFF8 -> SrcOut=10, Field=0xFFFFFE, latency 4.
- Branch (10) boundaries:
  - 0x01FFFFFC -> Field=0x7FFFFF, Fits=1.
  - 0xFE000000 -> Field=0x800000, Fits=1.
  - 0x02000000 -> Fits=0.
  - 0x00000006 -> Fits=0 (misaligned).
- Backpressure: hold OutReady=0 for 5 cycles -> OutValid stays 1, outputs stable, InReady=0, an InValid pulse is ignored. OutReady=1 -> IDLE next cycle.
- Random auto requests, 10k: on Fits=1, the round-trip invariant holds. On Fits=0, no encoding fits.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared constants, widths and FSM states for the immediate encoder
package imm_pkg;

  localparam int VALUE_W = 32;
  localparam int FIELD_W = 24;

  localparam logic [1:0] IMM_8U   = 2'b00;
  localparam logic [1:0] IMM_12U  = 2'b01;
  localparam logic [1:0] IMM_BR24 = 2'b10;
  localparam logic [1:0] IMM_AUTO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/imm_fit_check.sv
// rtl/imm_fit_check.sv - combinational fit test and field extraction for one candidate encoding
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [1:0]         cand,
  input  logic [VALUE_W-1:0] value,
  output logic               fits,
  output logic [FIELD_W-1:0] field
);

  always_comb begin
    fits  = 1'b0;
    field = '0;
    case (cand)
      IMM_8U: begin
        fits  = (value[31:8] == 24'd0);
        field = {16'd0, value[7:0]};
      end
      IMM_12U: begin
        fits  = (value[31:12] == 20'd0);
        field = {12'd0, value[11:0]};
      end
      IMM_BR24: begin
        // bits 31..25 must all equal the field sign bit (bit 25)
        fits  = (value[1:0] == 2'b00) &&
                ((value[31:25] == 7'h00) || (value[31:25] == 7'h7F));
        field = value[25:2];
      end
      default: begin
        fits  = 1'b0;
        field = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - sequential immediate encoder; auto mode walks the encodings narrowest-first
module imm_encoder
  import imm_pkg::*;
#(
  parameter bit ALLOW_AUTO = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [VALUE_W-1:0] Value,
  input  logic [1:0]         ImmSrc,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [FIELD_W-1:0] Field,
  output logic [1:0]         SrcOut,
  output logic               Fits
);

  state_t               state_q, state_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic [1:0]           cand_q, cand_d;
  logic                 auto_q, auto_d;
  logic [FIELD_W-1:0]   field_q, field_d;
  logic [1:0]           src_q, src_d;
  logic                 fits_q, fits_d;

  logic                 cand_fits;
  logic [FIELD_W-1:0]   cand_field;

  imm_fit_check u_fit (
    .cand  (cand_q),
    .value (value_q),
    .fits  (cand_fits),
    .field (cand_field)
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    cand_d  = cand_q;
    auto_d  = auto_q;
    field_d = field_q;
    src_d   = src_q;
    fits_d  = fits_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          value_d = Value;
          auto_d  = ALLOW_AUTO && (ImmSrc == IMM_AUTO);
          // with auto disabled, 11 stays the candidate and simply never fits
          cand_d  = (ALLOW_AUTO && (ImmSrc == IMM_AUTO)) ? IMM_8U : ImmSrc;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cand_fits) begin
          field_d = cand_field;
          src_d   = cand_q;
          fits_d  = 1'b1;
          state_d = DONE;
        end else if (auto_q && (cand_q < IMM_BR24)) begin
          cand_d  = cand_q + 2'd1;
        end else begin
          field_d = '0;
          src_d   = cand_q;
          fits_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      cand_q  <= IMM_8U;
      auto_q  <= 1'b0;
      field_q <= '0;
      src_q   <= IMM_8U;
      fits_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cand_q  <= cand_d;
      auto_q  <= auto_d;
      field_q <= field_d;
      src_q   <= src_d;
      fits_q  <= fits_d;
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign Field    = field_q;
  assign SrcOut   = src_q;
  assign Fits     = fits_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - randomized self-checking bench for imm_encoder against an arithmetic reference model
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] Value;
  logic [1:0]  ImmSrc;
  logic        OutValid;
  logic        OutReady;
  logic [23:0] Field;
  logic [1:0]  SrcOut;
  logic        Fits;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  imm_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .Value    (Value),
    .ImmSrc   (ImmSrc),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Field    (Field),
    .SrcOut   (SrcOut),
    .Fits     (Fits)
  );

  always #5 clk = ~clk;

  // Reference: numeric range tests on the value, trying encodings in narrowest-first order
  function automatic void model(input logic [31:0] v, input logic [1:0] s,
                                output logic ft, output logic [1:0] so,
                                output logic [23:0] f, output int lat);
    longint sv;
    int     n_try;
    int     first;
    sv    = longint'($signed(v));
    first = (s == 2'b11) ? 0 : int'(s);
    n_try = (s == 2'b11) ? 3 : 1;
    ft = 1'b0; f = 24'd0; so = s; lat = 1;
    for (int k = first; k < first + n_try; k++) begin
      lat++;
      so = k[1:0];
      if (k == 0 && v < 32'd256) begin
        ft = 1'b1; f = v[23:0]; break;
      end
      if (k == 1 && v < 32'd4096) begin
        ft = 1'b1; f = v[23:0]; break;
      end
      if (k == 2 && (sv % 4 == 0) && sv >= -longint'(33554432) && sv <= longint'(33554428)) begin
        longint q;
        q  = sv / 4;
        ft = 1'b1; f = q[23:0]; break;
      end
    end
  endfunction

  function automatic logic [31:0] extend(input logic [23:0] f, input logic [1:0] so);
    case (so)
      2'b00:   return {24'd0, f[7:0]};
      2'b01:   return {20'd0, f[11:0]};
      2'b10:   return {{6{f[23]}}, f, 2'b00};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic send(input logic [31:0] v, input logic [1:0] s, output int lat,
                      output logic [23:0] f, output logic [1:0] so, output logic ft);
    @(negedge clk);
    Value = v; ImmSrc = s; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; Value = $urandom; ImmSrc = 2'($urandom);
    lat = 1;
    while (!OutValid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    f = Field; so = SrcOut; ft = Fits;
  endtask

  task automatic release_out();
    @(negedge clk);
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Value = '0; ImmSrc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (InReady !== 1'b1) $display("FAIL reset_inready got=%b exp=1", InReady); else pass_cnt++;
    chk_cnt++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got=%b exp=0", OutValid); else pass_cnt++;
    chk_cnt++; if (Field !== 24'd0) $display("FAIL reset_field got=%h exp=000000", Field); else pass_cnt++;
    chk_cnt++; if (SrcOut !== 2'b00) $display("FAIL reset_srcout got=%b exp=00", SrcOut); else pass_cnt++;
    chk_cnt++; if (Fits !== 1'b0) $display("FAIL reset_fits got=%b exp=0", Fits); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_case(input string name, input logic [31:0] v, input logic [1:0] s);
    int lat, elat;
    logic [23:0] f, ef;
    logic [1:0]  so, eso;
    logic        ft, eft;
    model(v, s, eft, eso, ef, elat);
    send(v, s, lat, f, so, ft);
    chk_cnt++;
    if (lat !== elat || ft !== eft || so !== eso || f !== ef)
      $display("FAIL %s v=%h src=%b got lat=%0d fits=%b so=%b field=%h exp lat=%0d fits=%b so=%b field=%h",
               name, v, s, lat, ft, so, f, elat, eft, eso, ef);
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_fixed();
    logic [31:0] vals [8] = '{32'h0000_00A5, 32'h0000_0100, 32'h01FF_FFFC, 32'hFE00_0000,
                              32'h0200_0000, 32'h0000_0006, 32'h0000_0FFF, 32'h0000_1000};
    logic [1:0]  srcs [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 8; i++) run_case("fixed", vals[i], srcs[i]);
  endtask

  task automatic test_fixed_constants();
    int lat;
    logic [23:0] f;
    logic [1:0]  so;
    logic        ft;
    send(32'h01FF_FFFC, 2'b10, lat, f, so, ft);
    chk_cnt++; if (f !== 24'h7FFFFF || ft !== 1'b1) $display("FAIL br_max got field=%h fits=%b exp field=7fffff fits=1", f, ft); else pass_cnt++;
    release_out();
    send(32'hFE00_0000, 2'b10, lat, f, so, ft);
    chk_cnt++; if (f !== 24'h800000 || ft !== 1'b1) $display("FAIL br_min got field=%h fits=%b exp field=800000 fits=1", f, ft); else pass_cnt++;
    release_out();
    send(32'h0000_0100, 2'b00, lat, f, so, ft);
    chk_cnt++; if (f !== 24'd0 || ft !== 1'b0 || so !== 2'b00) $display("FAIL u8_over got field=%h fits=%b so=%b exp 000000/0/00", f, ft, so); else pass_cnt++;
    release_out();
  endtask

  task automatic test_auto();
    logic [31:0] vals [7] = '{32'h0000_0ABC, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0005,
                              32'h0200_0000, 32'h1234_5678, 32'h0000_1004};
    int lat;
    logic [23:0] f;
    logic [1:0]  so;
    logic        ft;
    for (int i = 0; i < 7; i++) run_case("auto", vals[i], 2'b11);
    send(32'hFFFF_FFF8, 2'b11, lat, f, so, ft);
    chk_cnt++;
    if (lat !== 4 || so !== 2'b10 || f !== 24'hFFFFFE)
      $display("FAIL auto_neg got lat=%0d so=%b field=%h exp lat=4 so=10 field=fffffe", lat, so, f);
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_reset_in_eval();
    int seen;
    @(negedge clk);
    Value = 32'hFFFF_FFF8; ImmSrc = 2'b11; InValid = 1'b1;
    @(negedge clk);
    InValid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_cnt++; if (InReady !== 1'b1 || OutValid !== 1'b0) $display("FAIL reset_eval_idle got inready=%b outvalid=%b exp 1/0", InReady, OutValid); else pass_cnt++;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (OutValid) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL reset_eval_nooutput got outvalid_cycles=%0d exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [23:0] f;
    logic [1:0]  so;
    logic        ft;
    send(32'h0000_0ABC, 2'b11, lat, f, so, ft);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      InValid = (c == 2); Value = 32'h0000_0001; ImmSrc = 2'b00;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || Field !== f || SrcOut !== so || Fits !== ft) bad++;
      @(posedge clk); #1;
      InValid = 1'b0;
    end
    chk_cnt++; if (bad !== 0) $display("FAIL backpressure_hold got unstable_cycles=%0d exp 0", bad); else pass_cnt++;
    chk_cnt++; if (f !== 24'h000ABC || so !== 2'b01 || ft !== 1'b1) $display("FAIL backpressure_result got field=%h so=%b fits=%b exp 000abc/01/1", f, so, ft); else pass_cnt++;
    release_out();
    chk_cnt++; if (OutValid !== 1'b0 || InReady !== 1'b1) $display("FAIL backpressure_release got outvalid=%b inready=%b exp 0/1", OutValid, InReady); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (OutValid !== 1'b0 || InReady !== 1'b1) $display("FAIL backpressure_ignored got outvalid=%b inready=%b exp 0/1", OutValid, InReady); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, elat, errs;
    logic [31:0] v;
    logic [23:0] f, ef;
    logic [1:0]  so, eso;
    logic        ft, eft;
    errs = 0;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 255);
        1: v = $urandom_range(0, 4095);
        2: v = {{7{$urandom_range(0, 1) == 1}}, 25'($urandom)} & ~32'h3;
        default: v = $urandom;
      endcase
      model(v, 2'b11, eft, eso, ef, elat);
      send(v, 2'b11, lat, f, so, ft);
      if (lat !== elat || ft !== eft || so !== eso || f !== ef || (ft && extend(f, so) !== v)) begin
        if (errs < 10)
          $display("FAIL random v=%h got lat=%0d fits=%b so=%b field=%h exp lat=%0d fits=%b so=%b field=%h",
                   v, lat, ft, so, f, elat, eft, eso, ef);
        errs++;
      end
      release_out();
    end
    chk_cnt++; if (errs !== 0) $display("FAIL random_total got errors=%0d exp 0", errs); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_fixed_constants();
    test_auto();
    test_reset_in_eval();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
